// File: rtl/fir_out_round_sat_buf.sv
// FIR output stage: round/shift the accumulator, saturate to OUT_W, buffer in a FWFT FIFO.
// Define FIR_OUT_CONVERGENT_EN for round-half-even; the default build rounds half-up.
module fir_out_round_sat_buf #(
    parameter int unsigned IN_W  = 48,
    parameter int unsigned SHIFT = 10,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    input  logic [IN_W-1:0]        s_data,
    output logic                   m_valid,
    output logic [OUT_W-1:0]       m_data,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            sat_cnt,
    output logic [15:0]            drop_cnt,
    output logic                   ovf,
    input  logic                   stat_clr
);
    localparam int unsigned AW = IN_W + 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic signed [AW-1:0] MAX_V = {{(AW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V = {{(AW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [AW-1:0] rnd;
    logic signed [AW-1:0] acc1_d, acc1_q;
    logic                 v1_d, v1_q;
    logic signed [AW-1:0] shr;
    logic [OUT_W-1:0]     out2_d, out2_q;
    logic                 sat2_d, sat2_q;
    logic                 v2_d, v2_q;

    logic [OUT_W-1:0]     mem_q [DEPTH];
    logic [PW-1:0]        wptr_d, wptr_q, rptr_d, rptr_q;
    logic [CW-1:0]        cnt_d, cnt_q;
    logic                 full, pop, push, drop;
    logic [15:0]          sat_cnt_d, sat_cnt_q, drop_cnt_d, drop_cnt_q;
    logic                 ovf_d, ovf_q;

    if (SHIFT > 0) begin : g_rnd
`ifdef FIR_OUT_CONVERGENT_EN
        // Half minus one LSB, plus the lowest kept bit: exact ties land on the even result.
        assign rnd = (AW'(1) << (SHIFT - 1)) - AW'(1) + AW'(s_data[SHIFT]);
`else
        assign rnd = AW'(1) << (SHIFT - 1);
`endif
    end else begin : g_no_rnd
        assign rnd = '0;
    end

    always_comb begin
        acc1_d = $signed({s_data[IN_W-1], s_data}) + rnd;
        v1_d   = s_valid;
    end

    always_comb begin
        shr    = acc1_q >>> SHIFT;
        out2_d = shr[OUT_W-1:0];
        sat2_d = 1'b0;
        if (shr > MAX_V) begin
            out2_d = MAX_V[OUT_W-1:0];
            sat2_d = 1'b1;
        end else if (shr < MIN_V) begin
            out2_d = MIN_V[OUT_W-1:0];
            sat2_d = 1'b1;
        end
        v2_d = v1_q;
    end

    assign m_valid = (cnt_q != '0);
    assign m_data  = m_valid ? mem_q[rptr_q] : '0;
    assign level   = cnt_q;

    // A pop at full frees the slot the same-cycle push lands in.
    always_comb begin
        full   = (cnt_q == CW'(DEPTH));
        pop    = m_valid && m_ready;
        push   = v2_q && (!full || pop);
        drop   = v2_q && full && !pop;
        wptr_d = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + PW'(1) : rptr_q;
        cnt_d  = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_comb begin
        sat_cnt_d  = sat_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        if (stat_clr) begin
            sat_cnt_d  = '0;
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            if (v2_q && sat2_q && sat_cnt_q != 16'hFFFF) begin
                sat_cnt_d = sat_cnt_q + 16'd1;
            end
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
        end
    end

    assign sat_cnt  = sat_cnt_q;
    assign drop_cnt = drop_cnt_q;
    assign ovf      = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc1_q     <= '0;
            v1_q       <= 1'b0;
            out2_q     <= '0;
            sat2_q     <= 1'b0;
            v2_q       <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            sat_cnt_q  <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            acc1_q     <= acc1_d;
            v1_q       <= v1_d;
            out2_q     <= out2_d;
            sat2_q     <= sat2_d;
            v2_q       <= v2_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            sat_cnt_q  <= sat_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wptr_q] <= out2_q;
        end
    end

endmodule

// File: tb/tb_fir_out_round_sat_buf.sv
// Bench for fir_out_round_sat_buf: real-arithmetic reference model with queue FIFO,
// per-cycle comparison plus directed literal checks.
module tb_fir_out_round_sat_buf;
    localparam int unsigned IN_W  = 48;
    localparam int unsigned SHIFT = 10;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic [IN_W-1:0]   s_data = '0;
    logic              m_ready = 1'b0;
    logic              stat_clr = 1'b0;
    logic              m_valid;
    logic [OUT_W-1:0]  m_data;
    logic [LW-1:0]     level;
    logic [15:0]       sat_cnt;
    logic [15:0]       drop_cnt;
    logic              ovf;

    int n_chk = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    longint mq[$];
    bit     p1v = 0, p2v = 0, p1s = 0, p2s = 0;
    longint p1d = 0, p2d = 0;
    int     m_sat = 0, m_drop = 0;
    bit     m_ovf = 0;

    localparam longint SATV = (longint'(1) << 25) - 1;

    fir_out_round_sat_buf #(
        .IN_W (IN_W),
        .SHIFT(SHIFT),
        .OUT_W(OUT_W),
        .DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .level   (level),
        .sat_cnt (sat_cnt),
        .drop_cnt(drop_cnt),
        .ovf     (ovf),
        .stat_clr(stat_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference rounding on real numbers: value / 2^SHIFT, then round and clamp.
    function automatic void ref_round(input longint x, output longint y, output bit sat);
        real    r, q, frac;
        longint qi, hi, lo;
        r    = real'(x) / real'(longint'(1) << SHIFT);
        q    = $floor(r);
        frac = r - q;
        qi   = longint'(q);
`ifdef FIR_OUT_CONVERGENT_EN
        if (frac > 0.5 || (frac == 0.5 && (qi % 2 != 0))) qi++;
`else
        if (frac >= 0.5) qi++;
`endif
        hi  = (longint'(1) << (OUT_W - 1)) - 1;
        lo  = -(longint'(1) << (OUT_W - 1));
        sat = 1'b0;
        y   = qi;
        if (qi > hi) begin
            y = hi;
            sat = 1'b1;
        end else if (qi < lo) begin
            y = lo;
            sat = 1'b1;
        end
    endfunction

    task automatic model_step();
        bit     pop, dropped, s;
        longint y;
        if (rst) begin
            mq.delete();
            p1v = 0; p2v = 0;
            m_sat = 0; m_drop = 0; m_ovf = 0;
            return;
        end
        pop = (mq.size() != 0) && m_ready;
        if (pop) void'(mq.pop_front());
        dropped = 0;
        if (p2v) begin
            if (mq.size() < DEPTH) mq.push_back(p2d);
            else dropped = 1;
        end
        if (stat_clr) begin
            m_sat = 0; m_drop = 0; m_ovf = 0;
        end else begin
            if (p2v && p2s && m_sat < 65535) m_sat++;
            if (dropped) begin
                if (m_drop < 65535) m_drop++;
                m_ovf = 1;
            end
        end
        p2v = p1v; p2d = p1d; p2s = p1s;
        ref_round(longint'($signed(s_data)), y, s);
        p1v = s_valid; p1d = y; p1s = s;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("m_valid", m_valid, mq.size() != 0);
            check("level", level, mq.size());
            if (mq.size() != 0) check("m_data", $signed(m_data), mq[0]);
            check("sat_cnt", sat_cnt, m_sat);
            check("drop_cnt", drop_cnt, m_drop);
            check("ovf", ovf, m_ovf);
        end
    end

    task automatic push_sample(input longint v);
        @(posedge clk);
        #2;
        s_valid = 1'b1;
        s_data  = v[IN_W-1:0];
    endtask

    task automatic idle();
        @(posedge clk);
        #2;
        s_valid = 1'b0;
    endtask

    task automatic single(input longint v, input longint exp, input string name);
        push_sample(v);
        idle();
        @(posedge clk);
        @(negedge clk);
        check({name, " early"}, m_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check({name, " valid"}, m_valid, 1);
        check(name, $signed(m_data), exp);
    endtask

    task automatic wait_level(input int target, input int budget, input string name);
        int n = 0;
        @(negedge clk);
        while (level != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, level, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        longint y;
        bit     s;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        check("reset m_valid", m_valid, 0);
        check("reset level", level, 0);
        check("reset m_data", m_data, 0);
        check("reset sat_cnt", sat_cnt, 0);
        check("reset drop_cnt", drop_cnt, 0);
        check("reset ovf", ovf, 0);

        ref_round(1536, y, s);
        check("model 1536", y, 2);
        ref_round(SATV, y, s);
        check("model sat max", y, 32767);
        check("model sat flag", s, 1);

        // Rounding, m_ready held high
        m_ready = 1'b1;
        single(1536, 2, "round 1536");
`ifdef FIR_OUT_CONVERGENT_EN
        single(2560, 2, "round 2560");
        single(-1536, -2, "round -1536");
`else
        single(2560, 3, "round 2560");
        single(-1536, -1, "round -1536");
`endif
        single(1023, 1, "round 1023");
        single(511, 0, "round 511");

        // Saturation
        single(SATV, 32767, "sat pos");
        check("sat_cnt after pos", sat_cnt, 1);
        single(-(longint'(1) << 25), -32768, "min exact");
        check("sat_cnt after min", sat_cnt, 1);
        single(-(longint'(1) << 25) - 1024, -32768, "sat neg");
        check("sat_cnt after neg", sat_cnt, 2);
        single((longint'(1) << 47) - 1, 32767, "sat huge");
        check("sat_cnt after huge", sat_cnt, 3);

        // Overflow with output stalled, then drain
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 1; i <= 20; i++) push_sample(longint'(i) << SHIFT);
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ovfl level", level, 16);
        check("ovfl drop_cnt", drop_cnt, 4);
        check("ovfl ovf", ovf, 1);
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check("drain valid", m_valid, 1);
            check("drain order", $signed(m_data), i);
            @(negedge clk);
        end
        check("drain empty", m_valid, 0);

        // Full FIFO with simultaneous push and pop
        m_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) push_sample(longint'(101 + i) << SHIFT);
                idle();
            end
            begin
                wait_level(16, 60, "fill to full");
                m_ready = 1'b1;
                repeat (20) begin
                    @(negedge clk);
                    check("full push+pop level", level, 16);
                end
            end
        join
        check("full no new drops", drop_cnt, 4);
        wait_level(0, 60, "drain after full");

        // stat_clr
        @(posedge clk);
        #2 stat_clr = 1'b1;
        @(posedge clk);
        #2 stat_clr = 1'b0;
        @(negedge clk);
        check("clr sat_cnt", sat_cnt, 0);
        check("clr drop_cnt", drop_cnt, 0);
        check("clr ovf", ovf, 0);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_sample(SATV);
        for (int i = 1; i <= 14; i++) push_sample(longint'(i) << SHIFT);
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre-clr sat_cnt", sat_cnt, 5);
        check("pre-clr drop_cnt", drop_cnt, 3);
        check("pre-clr ovf", ovf, 1);
        push_sample(SATV);
        idle();
        @(posedge clk);
        #2 stat_clr = 1'b1;
        @(posedge clk);
        #2 stat_clr = 1'b0;
        @(negedge clk);
        check("clr prio sat_cnt", sat_cnt, 0);
        check("clr prio drop_cnt", drop_cnt, 0);
        check("clr prio ovf", ovf, 0);
        check("clr keeps fifo", level, 16);

        // Reset mid-stream with 8 entries queued
        m_ready = 1'b1;
        wait_level(7, 40, "partial drain");
        m_ready = 1'b0;
        push_sample(SATV);
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre-rst level", level, 8);
        check("pre-rst sat_cnt", sat_cnt, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        s_valid = 1'b1;
        s_data = IN_W'(5 << SHIFT);
        @(posedge clk);
        #2;
        rst = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("rst m_valid", m_valid, 0);
        check("rst level", level, 0);
        check("rst sat_cnt", sat_cnt, 0);
        check("rst drop_cnt", drop_cnt, 0);
        check("rst ovf", ovf, 0);
        m_ready = 1'b1;
        single(longint'(7) << SHIFT, 7, "post-rst sample");
        repeat (3) @(negedge clk);
        check("post-rst empty", m_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
